// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream compactor: FSM states, lane-count type, popcount.
package stream_pkg;

  localparam int unsigned DEF_LANES  = 4;
  localparam int unsigned DEF_CNT_W  = $clog2(DEF_LANES + 1);
  localparam int unsigned POPCNT_MAX = 64;

  typedef logic [DEF_CNT_W-1:0] cnt_t;

  typedef enum logic {
    RUN,
    FLUSH
  } compact_state_e;

  function automatic logic [7:0] popcount(input logic [POPCNT_MAX-1:0] v);
    logic [7:0] c;
    c = '0;
    for (int unsigned i = 0; i < POPCNT_MAX; i++) begin
      c = c + 8'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Multi-lane stream interface: per-lane valid mask, packet last flag, valid/ready handshake.
interface axi_stream_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PARALLELISM = 4
);
  logic [PARALLELISM-1:0][DATA_WIDTH-1:0] data;
  logic [PARALLELISM-1:0]                 mask;
  logic                                   last;
  logic                                   valid;
  logic                                   ready;

  modport master (output data, mask, last, valid, input ready);
  modport slave  (input data, mask, last, valid, output ready);
endinterface

// File: rtl/lane_compactor.sv
// Combinational lane packer: residual lanes first, then masked input lanes at prefix-sum positions.
module lane_compactor
  import stream_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  int unsigned PARALLELISM = 4,
  localparam int unsigned CNT_W       = $clog2(PARALLELISM + 1),
  localparam int unsigned TOT_W       = $clog2(2 * PARALLELISM)
) (
  input  logic [CNT_W-1:0]                         i_cnt,
  input  logic [PARALLELISM-2:0][DATA_WIDTH-1:0]   i_res,
  input  logic [PARALLELISM-1:0][DATA_WIDTH-1:0]   i_data,
  input  logic [PARALLELISM-1:0]                   i_mask,
  output logic [2*PARALLELISM-2:0][DATA_WIDTH-1:0] o_lanes,
  output logic [TOT_W-1:0]                         o_tot
);

  logic [PARALLELISM-1:0][TOT_W-1:0] w_dest;

  always_comb begin
    logic [TOT_W-1:0] acc;
    acc = TOT_W'(i_cnt);
    for (int unsigned i = 0; i < PARALLELISM; i++) begin
      w_dest[i] = acc;
      acc       = acc + TOT_W'(i_mask[i]);
    end
  end

  // Lanes past tot stay zero; the top relies on that for the residual tail.
  always_comb begin
    o_lanes = '0;
    for (int unsigned j = 0; j < PARALLELISM - 1; j++) begin
      if (CNT_W'(j) < i_cnt) o_lanes[j] = i_res[j];
    end
    for (int unsigned i = 0; i < PARALLELISM; i++) begin
      for (int unsigned j = 0; j < 2 * PARALLELISM - 1; j++) begin
        if (i_mask[i] && (w_dest[i] == TOT_W'(j))) o_lanes[j] = i_data[i];
      end
    end
  end

  assign o_tot = TOT_W'(i_cnt) + TOT_W'(popcount(POPCNT_MAX'(i_mask)));

endmodule

// File: rtl/axi_stream_compactor.sv
// Packs sparse masked stream beats into dense beats, preserving order and packet boundaries.
module axi_stream_compactor
  import stream_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  int unsigned PARALLELISM = 4,
  localparam int unsigned CNT_W       = $clog2(PARALLELISM + 1),
  localparam int unsigned TOT_W       = $clog2(2 * PARALLELISM)
) (
  input  logic         clk,
  input  logic         rst_n,
  axi_stream_if.slave  s,
  axi_stream_if.master m
);

  localparam int unsigned P = PARALLELISM;

  compact_state_e                 r_state, w_state_nxt;
  logic [CNT_W-1:0]               r_cnt, w_cnt_nxt;
  logic [P-2:0][DATA_WIDTH-1:0]   r_res, w_res_nxt;
  logic [P-1:0][DATA_WIDTH-1:0]   r_data, w_data_nxt;
  logic [P-1:0]                   r_mask, w_mask_nxt;
  logic                           r_last, w_last_nxt;
  logic                           r_valid, w_valid_nxt;
  logic                           r_en;

  logic [2*P-2:0][DATA_WIDTH-1:0] w_lanes;
  logic [TOT_W-1:0]               w_tot;
  logic                           w_free;
  logic                           w_s_ready;
  logic                           w_acc;

  function automatic logic [P-1:0] lane_mask(input logic [TOT_W-1:0] k);
    logic [P-1:0] mk;
    for (int unsigned i = 0; i < P; i++) mk[i] = (TOT_W'(i) < k);
    return mk;
  endfunction

  lane_compactor #(
    .DATA_WIDTH (DATA_WIDTH),
    .PARALLELISM(PARALLELISM)
  ) u_lane_compactor (
    .i_cnt  (r_cnt),
    .i_res  (r_res),
    .i_data (s.data),
    .i_mask (s.mask),
    .o_lanes(w_lanes),
    .o_tot  (w_tot)
  );

  // r_en holds s.ready low through reset and releases it on the first edge afterwards.
  assign w_free    = !r_valid || m.ready;
  assign w_s_ready = r_en && (r_state == RUN) && w_free;
  assign w_acc     = s.valid && w_s_ready;
  assign s.ready   = w_s_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_res_nxt   = r_res;
    w_data_nxt  = r_data;
    w_mask_nxt  = r_mask;
    w_last_nxt  = r_last;
    w_valid_nxt = r_valid && !m.ready;
    case (r_state)
      RUN: begin
        if (w_acc) begin
          if (w_tot >= TOT_W'(P)) begin
            w_data_nxt  = w_lanes[P-1:0];
            w_mask_nxt  = '1;
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = CNT_W'(w_tot - TOT_W'(P));
            w_res_nxt   = w_lanes[2*P-2:P];
            w_last_nxt  = s.last && (w_tot == TOT_W'(P));
            if (s.last && (w_tot != TOT_W'(P))) w_state_nxt = FLUSH;
          end else if (s.last) begin
            w_data_nxt  = w_lanes[P-1:0];
            w_mask_nxt  = lane_mask(w_tot);
            w_last_nxt  = 1'b1;
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_res_nxt   = '0;
          end else begin
            w_cnt_nxt = CNT_W'(w_tot);
            w_res_nxt = w_lanes[P-2:0];
          end
        end
      end
      FLUSH: begin
        if (w_free) begin
          w_data_nxt = '0;
          for (int unsigned j = 0; j < P - 1; j++) w_data_nxt[j] = r_res[j];
          w_mask_nxt  = lane_mask(TOT_W'(r_cnt));
          w_last_nxt  = 1'b1;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_res_nxt   = '0;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_res   <= '0;
      r_data  <= '0;
      r_mask  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_res   <= w_res_nxt;
      r_data  <= w_data_nxt;
      r_mask  <= w_mask_nxt;
      r_last  <= w_last_nxt;
      r_valid <= w_valid_nxt;
      r_en    <= 1'b1;
    end
  end

  assign m.data  = r_data;
  assign m.mask  = r_mask;
  assign m.last  = r_last;
  assign m.valid = r_valid;

endmodule
